// File: rtl/cp0_ir_arbiter.sv
// Round-robin arbiter for external interrupt lines feeding CP0's single ir_in.
// Holds the request until CP0 accepts, then blocks re-entry until ERET.
module cp0_ir_arbiter #(
   parameter int                 N_SRC    = 8,
   parameter int                 ID_W     = 3,
   parameter logic [N_SRC-1:0]   MASK_RST = {N_SRC{1'b1}},
   parameter int                 ACK_TMO  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_in,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   output logic [N_SRC-1:0] mask_r,
   output logic [N_SRC-1:0] pending_r,
   input  logic             ir_ack,
   input  logic             eret,
   output logic             ir_out,
   output logic [ID_W-1:0]  cause_id,
   output logic             cause_valid,
   output logic             tmo_flag
);

   localparam int CNT_W = $clog2(ACK_TMO + 1);

   typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

   state_t            state_q, state_d;
   logic [N_SRC-1:0]  src_prev_q;
   logic [N_SRC-1:0]  pending_q, pending_d;
   logic [N_SRC-1:0]  mask_q, mask_d;
   logic              ir_out_q, ir_out_d;
   logic [ID_W-1:0]   cause_id_q, cause_id_d;
   logic              cause_valid_q, cause_valid_d;
   logic              tmo_flag_q, tmo_flag_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

   logic [N_SRC-1:0]  src_edge;
   logic [N_SRC-1:0]  req;
   logic [N_SRC-1:0]  clr;
   logic              win_found;
   logic [ID_W-1:0]   win_id;
   logic [ID_W-1:0]   scan_idx;

   assign src_edge = src_in & ~src_prev_q;
   assign req      = pending_q & mask_q;

   // First requesting source at or after rr_ptr, wrapping modulo N_SRC.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int k = 0; k < N_SRC; k++) begin
         scan_idx = ID_W'((int'(rr_ptr_q) + k) % N_SRC);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ir_out_d      = ir_out_q;
      cause_id_d    = cause_id_q;
      cause_valid_d = cause_valid_q;
      rr_ptr_d      = rr_ptr_q;
      tmo_cnt_d     = tmo_cnt_q;
      tmo_flag_d    = tmo_flag_q;
      mask_d        = mask_q;
      clr           = '0;

      if (mask_we) begin
         mask_d     = mask_wdata;
         tmo_flag_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (win_found) begin
               cause_id_d    = win_id;
               cause_valid_d = 1'b1;
               ir_out_d      = 1'b1;
               tmo_cnt_d     = '0;
               state_d       = REQ;
            end
         end
         REQ: begin
            // An ack arriving on the expiry cycle is honoured, not abandoned.
            if (ir_ack) begin
               ir_out_d       = 1'b0;
               clr[cause_id_q] = 1'b1;
               rr_ptr_d       = (cause_id_q == ID_W'(N_SRC - 1)) ? '0 : cause_id_q + ID_W'(1);
               state_d        = SERV;
            end else if (tmo_cnt_q == CNT_W'(ACK_TMO - 1)) begin
               ir_out_d   = 1'b0;
               tmo_flag_d = 1'b1;
               state_d    = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
         end
         SERV: begin
            if (eret) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      pending_d = (pending_q & ~clr) | src_edge;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         src_prev_q    <= '0;
         pending_q     <= '0;
         mask_q        <= MASK_RST;
         ir_out_q      <= 1'b0;
         cause_id_q    <= '0;
         cause_valid_q <= 1'b0;
         tmo_flag_q    <= 1'b0;
         rr_ptr_q      <= '0;
         tmo_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         src_prev_q    <= src_in;
         pending_q     <= pending_d;
         mask_q        <= mask_d;
         ir_out_q      <= ir_out_d;
         cause_id_q    <= cause_id_d;
         cause_valid_q <= cause_valid_d;
         tmo_flag_q    <= tmo_flag_d;
         rr_ptr_q      <= rr_ptr_d;
         tmo_cnt_q     <= tmo_cnt_d;
      end
   end

   assign mask_r      = mask_q;
   assign pending_r   = pending_q;
   assign ir_out      = ir_out_q;
   assign cause_id    = cause_id_q;
   assign cause_valid = cause_valid_q;
   assign tmo_flag    = tmo_flag_q;

endmodule
